// File: rtl/eda_visited_map_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eda_visited_map_pkg
// Purpose : Shared configuration constants and types for the visited map.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 3
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 3
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 6
`endif

package eda_visited_map_pkg;
    localparam int C_ADDR_WIDTH = `CFG_ADDR_WIDTH;

    typedef logic [C_ADDR_WIDTH-1:0] pix_addr_t;

    typedef enum logic [0:0] {
        READY    = 1'b0,
        CLEARING = 1'b1
    } clear_state_t;
endpackage
`default_nettype wire

// File: rtl/eda_one_hot_to_bin.sv
`default_nettype none
// ============================================================================
// Module  : eda_one_hot_to_bin
// Purpose : One-hot to binary encoder (all-zero input encodes to 0).
// Revision: 1.0 - initial release
// ============================================================================
module eda_one_hot_to_bin #(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 2
) (
    input  logic [WIDTH-1:0]     onehot,
    output logic [OUT_WIDTH-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                bin = bin | OUT_WIDTH'(i);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/eda_visited_finder.sv
`default_nettype none
// ============================================================================
// Module  : eda_visited_finder
// Purpose : Row-then-column priority finder for the lowest set bit in an
//           M x N raster-ordered bit vector.
// Revision: 1.0 - initial release
// ============================================================================
module eda_visited_finder #(
    parameter int M       = 4,
    parameter int N       = 4,
    parameter int I_WIDTH = 3,
    parameter int J_WIDTH = 3
) (
    input  logic [M*N-1:0]     unvisited,
    output logic               found,
    output logic [I_WIDTH-1:0] row,
    output logic [J_WIDTH-1:0] col
);
    logic [M-1:0] w_row_any;
    logic [M-1:0] w_row_oh;
    logic [N-1:0] w_row_bits;
    logic [N-1:0] w_col_oh;

    generate
        for (genvar r = 0; r < M; r++) begin : g_row_any
            assign w_row_any[r] = |unvisited[r*N +: N];
        end
    endgenerate

    // x & -x isolates the lowest set bit
    assign w_row_oh = w_row_any & (~w_row_any + M'(1));

    always_comb begin
        w_row_bits = '0;
        for (int r = 0; r < M; r++) begin
            if (w_row_oh[r]) begin
                w_row_bits = unvisited[r*N +: N];
            end
        end
    end

    assign w_col_oh = w_row_bits & (~w_row_bits + N'(1));
    assign found    = |w_row_any;

    eda_one_hot_to_bin #(.WIDTH(M), .OUT_WIDTH(I_WIDTH)) u_row_enc (
        .onehot (w_row_oh),
        .bin    (row)
    );

    eda_one_hot_to_bin #(.WIDTH(N), .OUT_WIDTH(J_WIDTH)) u_col_enc (
        .onehot (w_col_oh),
        .bin    (col)
    );
endmodule
`default_nettype wire

// File: rtl/eda_visited_map.sv
`default_nettype none
// ============================================================================
// Module  : eda_visited_map
// Purpose : Visited-pixel bitmap with multi-port mark/query, registered
//           next-unvisited finder, clear sequencer and visited counter.
// Revision: 1.0 - initial release
// ============================================================================
module eda_visited_map
    import eda_visited_map_pkg::*;
#(
    parameter int M          = `CFG_M,
    parameter int N          = `CFG_N,
    parameter int I_WIDTH    = `CFG_I_WIDTH,
    parameter int J_WIDTH    = `CFG_J_WIDTH,
    parameter int ADDR_WIDTH = `CFG_ADDR_WIDTH,
    parameter int N_PORTS    = 9,
    parameter int CLR_ROWS   = 2,
    parameter int CNT_WIDTH  = $clog2(M*N+1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clear_req,
    output logic                               clear_busy,
    output logic                               clear_done,
    input  logic [N_PORTS-1:0]                 mark_valid,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0] mark_addr,
    input  logic [N_PORTS-1:0]                 qry_valid,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0] qry_addr,
    output logic [N_PORTS-1:0]                 qry_visited,
    output logic                               next_valid,
    output logic [I_WIDTH-1:0]                 next_row,
    output logic [J_WIDTH-1:0]                 next_col,
    input  logic                               next_take,
    output logic [CNT_WIDTH-1:0]               visited_cnt,
    output logic                               all_visited
);
    localparam int c_NUM_PIX = M*N;

    clear_state_t             r_state, w_state_next;
    logic [c_NUM_PIX-1:0]     r_bitmap, w_bitmap_next, w_set_mask, w_clr_mask, w_new_bits;
    logic [I_WIDTH:0]         r_ptr;
    logic                     r_next_valid, r_all_visited;
    logic [I_WIDTH-1:0]       r_next_row, w_find_row;
    logic [J_WIDTH-1:0]       r_next_col, w_find_col;
    logic [CNT_WIDTH-1:0]     r_cnt, w_cnt_next, w_pop;
    logic                     w_clearing, w_last, w_accept, w_found;

    // Raster index of an {i,j} address, or -1 when it lies outside the image
    function automatic int pix_index(input logic [ADDR_WIDTH-1:0] a);
        int i;
        int j;
        i = int'(a[ADDR_WIDTH-1:J_WIDTH]);
        j = int'(a[J_WIDTH-1:0]);
        return (i < M && j < N) ? (i*N + j) : -1;
    endfunction

    assign w_clearing = (r_state == CLEARING);
    assign w_last     = (int'(r_ptr) + CLR_ROWS) >= M;
    assign w_accept   = !w_clearing && !clear_req;

    always_comb begin
        int idx;
        w_set_mask = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = pix_index(mark_addr[k]);
            for (int p = 0; p < c_NUM_PIX; p++) begin
                if (mark_valid[k] && idx == p) w_set_mask[p] = 1'b1;
            end
        end
        idx = int'(r_next_row)*N + int'(r_next_col);
        for (int p = 0; p < c_NUM_PIX; p++) begin
            if (next_take && r_next_valid && idx == p) w_set_mask[p] = 1'b1;
        end
    end

    always_comb begin
        w_clr_mask = '0;
        for (int r = 0; r < M; r++) begin
            if (r >= int'(r_ptr) && r < int'(r_ptr) + CLR_ROWS) w_clr_mask[r*N +: N] = '1;
        end
    end

    always_comb begin
        if (w_clearing)    w_bitmap_next = r_bitmap & ~w_clr_mask;
        else if (w_accept) w_bitmap_next = r_bitmap | w_set_mask;
        else               w_bitmap_next = r_bitmap;
    end

    // Queries see the pre-write bitmap; out-of-range reads as visited
    always_comb begin
        int idx;
        qry_visited = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = pix_index(qry_addr[k]);
            if (qry_valid[k] && idx < 0) qry_visited[k] = 1'b1;
            for (int p = 0; p < c_NUM_PIX; p++) begin
                if (qry_valid[k] && idx == p) qry_visited[k] = r_bitmap[p];
            end
        end
    end

    assign w_new_bits = w_bitmap_next & ~r_bitmap;

    always_comb begin
        w_pop = '0;
        for (int p = 0; p < c_NUM_PIX; p++) begin
            w_pop = w_pop + CNT_WIDTH'(w_new_bits[p]);
        end
    end

    assign w_cnt_next = w_accept ? (r_cnt + w_pop) : '0;

    always_comb begin
        w_state_next = r_state;
        clear_done   = 1'b0;
        case (r_state)
            READY: begin
                if (clear_req) w_state_next = CLEARING;
            end
            CLEARING: begin
                if (w_last) begin
                    clear_done   = 1'b1;
                    w_state_next = READY;
                end
            end
            default: w_state_next = READY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= READY;
        else          r_state <= w_state_next;
    end

    eda_visited_finder #(.M(M), .N(N), .I_WIDTH(I_WIDTH), .J_WIDTH(J_WIDTH)) u_finder (
        .unvisited (~w_bitmap_next),
        .found     (w_found),
        .row       (w_find_row),
        .col       (w_find_col)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitmap      <= '0;
            r_ptr         <= '0;
            r_next_valid  <= 1'b0;
            r_next_row    <= '0;
            r_next_col    <= '0;
            r_cnt         <= '0;
            r_all_visited <= 1'b0;
        end else begin
            r_bitmap      <= w_bitmap_next;
            r_ptr         <= w_clearing ? (r_ptr + (I_WIDTH+1)'(CLR_ROWS)) : '0;
            r_next_valid  <= w_found && (w_state_next == READY);
            r_next_row    <= w_find_row;
            r_next_col    <= w_find_col;
            r_cnt         <= w_cnt_next;
            r_all_visited <= (w_cnt_next == CNT_WIDTH'(c_NUM_PIX));
        end
    end

    assign clear_busy  = w_clearing;
    assign next_valid  = r_next_valid;
    assign next_row    = r_next_row;
    assign next_col    = r_next_col;
    assign visited_cnt = r_cnt;
    assign all_visited = r_all_visited;
endmodule
`default_nettype wire

// File: tb/tb_eda_visited_map.sv
`default_nettype none
// ============================================================================
// Module  : tb_eda_visited_map
// Purpose : Self-checking bench for eda_visited_map (M=4, N=4, 9 ports).
// Revision: 1.0 - initial release
// ============================================================================
module tb_eda_visited_map;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int P  = 9;
    localparam int AW = 6;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               clear_req;
    logic               clear_busy, clear_done;
    logic [P-1:0]       mark_valid, qry_valid, qry_visited;
    logic [P-1:0][AW-1:0] mark_addr, qry_addr;
    logic               next_valid;
    logic [2:0]         next_row, next_col;
    logic               next_take;
    logic [4:0]         visited_cnt;
    logic               all_visited;

    always #5 clk = ~clk;

    eda_visited_map #(
        .M(M), .N(N), .I_WIDTH(3), .J_WIDTH(3), .ADDR_WIDTH(AW),
        .N_PORTS(P), .CLR_ROWS(2), .CNT_WIDTH(5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mark_valid  (mark_valid),
        .mark_addr   (mark_addr),
        .qry_valid   (qry_valid),
        .qry_addr    (qry_addr),
        .qry_visited (qry_visited),
        .next_valid  (next_valid),
        .next_row    (next_row),
        .next_col    (next_col),
        .next_take   (next_take),
        .visited_cnt (visited_cnt),
        .all_visited (all_visited)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model: plain 2-D bit array plus clear progress
    bit   mdl [M][N];
    bit   m_clr;
    int   m_ptr;
    bit   m_nv;
    int   m_idx;
    logic [P-1:0] s_qry;
    logic s_busy, s_done;

    typedef struct {
        logic [P-1:0]         mv;
        logic [P-1:0][AW-1:0] ma;
        logic                 take;
        logic [P-1:0]         qv;
        logic [P-1:0][AW-1:0] qa;
        logic [P-1:0]         exp_q;
        int                   exp_cnt;
        logic                 exp_nv;
        int                   exp_row;
        int                   exp_col;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] pa(input int i, input int j);
        return {i[2:0], j[2:0]};
    endfunction

    function automatic int first_free();
        for (int p = 0; p < M*N; p++) if (!mdl[p/N][p%N]) return p;
        return -1;
    endfunction

    function automatic int m_count();
        int s = 0;
        for (int p = 0; p < M*N; p++) s += int'(mdl[p/N][p%N]);
        return s;
    endfunction

    task automatic set_idle();
        clear_req  = 1'b0;
        mark_valid = '0;
        mark_addr  = '0;
        qry_valid  = '0;
        qry_addr   = '0;
        next_take  = 1'b0;
    endtask

    task automatic check_comb();
        int i, j;
        logic e;
        s_qry  = qry_visited;
        s_busy = clear_busy;
        s_done = clear_done;
        chk("clear_busy", 32'(clear_busy), 32'(m_clr));
        chk("clear_done", 32'(clear_done), 32'(m_clr && (m_ptr + 2 >= M)));
        for (int k = 0; k < P; k++) begin
            i = int'(qry_addr[k][5:3]);
            j = int'(qry_addr[k][2:0]);
            if (!qry_valid[k])          e = 1'b0;
            else if (i >= M || j >= N)  e = 1'b1;
            else                        e = mdl[i][j];
            chk("qry_visited", 32'(qry_visited[k]), 32'(e));
        end
    endtask

    task automatic model_update();
        int i, j;
        if (m_clr) begin
            for (int r = m_ptr; r < m_ptr + 2 && r < M; r++)
                for (int c = 0; c < N; c++) mdl[r][c] = 1'b0;
            m_ptr += 2;
            if (m_ptr >= M) m_clr = 1'b0;
        end else if (clear_req) begin
            m_clr = 1'b1;
            m_ptr = 0;
        end else begin
            for (int k = 0; k < P; k++) begin
                i = int'(mark_addr[k][5:3]);
                j = int'(mark_addr[k][2:0]);
                if (mark_valid[k] && i < M && j < N) mdl[i][j] = 1'b1;
            end
            if (next_take && m_nv) mdl[m_idx/N][m_idx%N] = 1'b1;
        end
    endtask

    task automatic check_reg();
        int f, c;
        f     = first_free();
        m_nv  = !m_clr && (f >= 0);
        m_idx = (f < 0) ? 0 : f;
        c     = m_clr ? 0 : m_count();
        chk("next_valid", 32'(next_valid), 32'(m_nv));
        if (m_nv) begin
            chk("next_row", 32'(next_row), 32'(m_idx / N));
            chk("next_col", 32'(next_col), 32'(m_idx % N));
        end
        chk("visited_cnt", 32'(visited_cnt), 32'(c));
        chk("all_visited", 32'(all_visited), 32'(c == M*N));
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        model_update();
        #1;
        check_reg();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_idle();
        for (int p = 0; p < M*N; p++) mdl[p/N][p%N] = 1'b0;
        m_clr = 1'b0; m_ptr = 0; m_nv = 1'b0; m_idx = 0;
        #2;
        chk("rst_next_valid", 32'(next_valid), 32'd0);
        chk("rst_next_row", 32'(next_row), 32'd0);
        chk("rst_next_col", 32'(next_col), 32'd0);
        chk("rst_cnt", 32'(visited_cnt), 32'd0);
        chk("rst_all", 32'(all_visited), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reg();
    endtask

    initial begin
        for (int t = 0; t < 5; t++) begin
            tbl[t].mv = '0; tbl[t].ma = '0; tbl[t].take = 1'b0;
            tbl[t].qv = '0; tbl[t].qa = '0;
        end
        tbl[0].qv = 9'h001; tbl[0].qa[0] = pa(5, 0);
        tbl[0].exp_q = 9'h001; tbl[0].exp_cnt = 0; tbl[0].exp_nv = 1; tbl[0].exp_row = 0; tbl[0].exp_col = 0;
        tbl[1].mv = 9'h007; tbl[1].ma[0] = pa(0, 0); tbl[1].ma[1] = pa(0, 1); tbl[1].ma[2] = pa(0, 1);
        tbl[1].qv = 9'h001; tbl[1].qa[0] = pa(0, 1);
        tbl[1].exp_q = 9'h000; tbl[1].exp_cnt = 2; tbl[1].exp_nv = 1; tbl[1].exp_row = 0; tbl[1].exp_col = 2;
        tbl[2].qv = 9'h001; tbl[2].qa[0] = pa(0, 1);
        tbl[2].exp_q = 9'h001; tbl[2].exp_cnt = 2; tbl[2].exp_nv = 1; tbl[2].exp_row = 0; tbl[2].exp_col = 2;
        tbl[3].mv = 9'h070; tbl[3].ma[4] = pa(0, 2); tbl[3].ma[5] = pa(6, 1); tbl[3].ma[6] = pa(1, 5);
        tbl[3].qv = 9'h019; tbl[3].qa[0] = pa(0, 2); tbl[3].qa[3] = pa(4, 0); tbl[3].qa[4] = pa(0, 7);
        tbl[3].exp_q = 9'h018; tbl[3].exp_cnt = 3; tbl[3].exp_nv = 1; tbl[3].exp_row = 0; tbl[3].exp_col = 3;
        tbl[4].take = 1'b1;
        tbl[4].exp_q = 9'h000; tbl[4].exp_cnt = 4; tbl[4].exp_nv = 1; tbl[4].exp_row = 1; tbl[4].exp_col = 0;

        do_reset();

        for (int t = 0; t < 5; t++) begin
            set_idle();
            mark_valid = tbl[t].mv; mark_addr = tbl[t].ma; next_take = tbl[t].take;
            qry_valid  = tbl[t].qv; qry_addr  = tbl[t].qa;
            run_cycle();
            chk("tbl_qry", 32'(s_qry), 32'(tbl[t].exp_q));
            chk("tbl_cnt", 32'(visited_cnt), 32'(tbl[t].exp_cnt));
            chk("tbl_nv", 32'(next_valid), 32'(tbl[t].exp_nv));
            chk("tbl_row", 32'(next_row), 32'(tbl[t].exp_row));
            chk("tbl_col", 32'(next_col), 32'(tbl[t].exp_col));
        end

        // Raster-order takes from an empty map
        do_reset();
        for (int k = 0; k < M*N; k++) begin
            chk("take_nv", 32'(next_valid), 32'd1);
            chk("take_row", 32'(next_row), 32'(k / N));
            chk("take_col", 32'(next_col), 32'(k % N));
            next_take = 1'b1;
            run_cycle();
        end
        run_cycle();
        chk("full_nv", 32'(next_valid), 32'd0);
        chk("full_all", 32'(all_visited), 32'd1);
        chk("full_cnt", 32'(visited_cnt), 32'd16);

        // Clear from full; a mark and take during the clear must be dropped
        set_idle();
        clear_req = 1'b1;
        run_cycle();
        set_idle();
        mark_valid = 9'h001; mark_addr[0] = pa(0, 0); next_take = 1'b1;
        run_cycle();
        chk("clr1_busy", 32'(s_busy), 32'd1);
        chk("clr1_done", 32'(s_done), 32'd0);
        run_cycle();
        chk("clr2_busy", 32'(s_busy), 32'd1);
        chk("clr2_done", 32'(s_done), 32'd1);
        chk("clr_cnt", 32'(visited_cnt), 32'd0);
        chk("clr_nv", 32'(next_valid), 32'd1);
        chk("clr_row", 32'(next_row), 32'd0);
        chk("clr_col", 32'(next_col), 32'd0);
        set_idle();
        run_cycle();
        chk("post_clr_busy", 32'(s_busy), 32'd0);

        // Reset asserted in the first clear cycle
        mark_valid = 9'h001; mark_addr[0] = pa(1, 1);
        run_cycle();
        set_idle();
        clear_req = 1'b1;
        run_cycle();
        chk("midclr_busy", 32'(clear_busy), 32'd1);
        do_reset();
        chk("midclr_cnt", 32'(visited_cnt), 32'd0);
        chk("midclr_nv", 32'(next_valid), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            set_idle();
            clear_req = ($urandom % 50) == 0;
            next_take = ($urandom % 3) == 0;
            for (int k = 0; k < P; k++) begin
                mark_valid[k] = ($urandom % 7) == 0;
                mark_addr[k]  = pa($urandom_range(0, 4), $urandom_range(0, 4));
                qry_valid[k]  = ($urandom % 2) == 0;
                qry_addr[k]   = pa($urandom_range(0, 5), $urandom_range(0, 5));
            end
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
